// File: rtl/seven_seg_capture.sv
// seven_seg_capture
// Receive side of a 4-digit multiplexed seven-segment bus. Synchronises the
// active-low digit enables and segment lines, waits for the bus to settle,
// then decodes the displayed hex digit into its slot. Tracks the 0..3 scan
// order to flag complete frames, flags illegal multi-digit enables, and
// drops 'active' when no digit has been captured for TIMEOUT cycles.
module seven_seg_capture #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 65535,
    parameter int TO_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  scan,
    input  logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  seg_ok,
    output logic        frame_done,
    output logic        scan_err,
    output logic        active
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0]   SETTLE_MAX  = CW'(SETTLE);
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [TO_W-1:0] TO_MAX      = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT - 1);

    typedef enum logic {
        S_WAIT,
        S_HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]      scan_m;
    logic [3:0]      scan_s;
    logic [7:0]      seg_m;
    logic [7:0]      seg_s;
    logic [11:0]     bus;
    logic [11:0]     prev_bus;
    logic            changed;
    logic [CW-1:0]   settle_cnt;
    logic            eval;
    logic            idx_valid;
    logic [1:0]      idx;
    logic            multi;
    logic            hex_hit;
    logic [3:0]      hex_val;
    logic            capture;
    logic [1:0]      expected;
    logic [TO_W-1:0] to_cnt;

    assign bus     = {scan_s, seg_s};
    assign changed = (bus != prev_bus);
    assign capture = eval && idx_valid;

    // Two-flop synchroniser; resets to the idle (all-off) bus level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_m <= '1;
            scan_s <= '1;
            seg_m  <= '1;
            seg_s  <= '1;
        end else begin
            scan_m <= scan;
            scan_s <= scan_m;
            seg_m  <= seg;
            seg_s  <= seg_m;
        end
    end

    // Count how long the synchronised bus has stayed unchanged, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_bus   <= '1;
            settle_cnt <= '0;
        end else begin
            prev_bus <= bus;
            if (changed) begin
                settle_cnt <= '0;
            end else if (settle_cnt != SETTLE_MAX) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Evaluate once when the settle count completes, then hold until the bus moves
    always_comb begin
        state_next = state;
        eval       = 1'b0;
        case (state)
            S_WAIT: begin
                if (!changed && (settle_cnt >= SETTLE_LAST)) begin
                    eval       = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (changed) begin
                    state_next = S_WAIT;
                end
            end
            default: state_next = S_WAIT;
        endcase
    end

    // Classify the digit enables: single enable, blanking, or illegal overlap
    always_comb begin
        idx_valid = 1'b0;
        idx       = 2'd0;
        case (scan_s)
            4'b1110: begin idx_valid = 1'b1; idx = 2'd0; end
            4'b1101: begin idx_valid = 1'b1; idx = 2'd1; end
            4'b1011: begin idx_valid = 1'b1; idx = 2'd2; end
            4'b0111: begin idx_valid = 1'b1; idx = 2'd3; end
            default: begin idx_valid = 1'b0; idx = 2'd0; end
        endcase
        multi = !idx_valid && (scan_s != 4'b1111);
    end

    // Reverse lookup of the active-low segment pattern into a hex nibble
    always_comb begin
        hex_hit = 1'b1;
        hex_val = 4'h0;
        case (seg_s[6:0])
            7'h40: hex_val = 4'h0;
            7'h79: hex_val = 4'h1;
            7'h24: hex_val = 4'h2;
            7'h30: hex_val = 4'h3;
            7'h19: hex_val = 4'h4;
            7'h12: hex_val = 4'h5;
            7'h02: hex_val = 4'h6;
            7'h78: hex_val = 4'h7;
            7'h00: hex_val = 4'h8;
            7'h10: hex_val = 4'h9;
            7'h08: hex_val = 4'hA;
            7'h03: hex_val = 4'hB;
            7'h46: hex_val = 4'hC;
            7'h21: hex_val = 4'hD;
            7'h06: hex_val = 4'hE;
            7'h0E: hex_val = 4'hF;
            default: hex_hit = 1'b0;
        endcase
    end

    // Update the captured digit slot, its decimal point and decode status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits <= '0;
            dp     <= '0;
            seg_ok <= '0;
        end else if (capture) begin
            dp[idx]     <= ~seg_s[7];
            seg_ok[idx] <= hex_hit;
            if (hex_hit) begin
                digits[{idx, 2'b00} +: 4] <= hex_val;
            end
        end
    end

    // Scan-order tracking, error/frame pulses and link-activity timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected   <= 2'd0;
            frame_done <= 1'b0;
            scan_err   <= 1'b0;
            to_cnt     <= '0;
            active     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            scan_err   <= 1'b0;
            if (capture) begin
                to_cnt <= '0;
                active <= 1'b1;
                if (idx == expected) begin
                    expected   <= idx + 2'd1;
                    frame_done <= (idx == 2'd3);
                end else begin
                    expected <= (idx == 2'd0) ? 2'd1 : 2'd0;
                end
            end else begin
                if (eval && multi) begin
                    scan_err <= 1'b1;
                    expected <= 2'd0;
                end
                if (to_cnt != TO_MAX) begin
                    to_cnt <= to_cnt + 1'b1;
                    if (to_cnt == TO_LAST) begin
                        active   <= 1'b0;
                        expected <= 2'd0;
                    end
                end
            end
        end
    end

endmodule
